cmd_bus_arbiter: RTL and testbench

Shares the internal command bus (addr/data/en/rd/wr toward the pin-control and DAC chippies) between NREQ requesters. Requester 0 is the time-driven command scheduler and has strict priority. Requesters 1..NREQ-1 are host direct-access and streaming engines and are served round-robin, with a fairness limit so that requester 0 cannot starve them. Each granted request becomes one registered bus transaction with a fixed hold window, followed by a one-cycle acknowledge.

---
 rtl/cmd_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cmd_bus_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_bus_arbiter.sv
// cmd_bus_arbiter
// Shares the internal command bus between NREQ requesters. Requester 0 (the
// command scheduler) has strict priority, bounded by MAX_CONSEC consecutive
// grants while others wait; requesters 1..NREQ-1 are served round-robin.
// Each grant becomes one registered bus transaction held for HOLD_CYCLES,
// followed by a single-cycle one-hot acknowledge.
module cmd_bus_arbiter #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_CONSEC  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ-1:0]         req_rd,
    input  logic [16*NREQ-1:0]      req_addr,
    input  logic [32*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         ack,
    output logic [31:0]             ack_rdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [15:0]             cmd_bus_addr,
    output logic [31:0]             cmd_bus_data,
    output logic                    cmd_bus_en,
    output logic                    cmd_bus_rd,
    output logic                    cmd_bus_wr,
    input  logic [31:0]             cmd_bus_rdata
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CON_W = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CON_W-1:0] consec;

    logic             any_req;
    logic             others;
    logic             pick0;
    logic             rr_hit;
    logic [ID_W-1:0]  rr_win;
    logic [ID_W-1:0]  win_id;
    logic [15:0]      win_addr;
    logic [31:0]      win_data;
    logic             win_rd;
    logic             win_wr;

    // Pick the winner: requester 0 unless its fairness budget is spent,
    // otherwise the next requester above rr_ptr, wrapping over 1..NREQ-1.
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        any_req = |req;
        others  = |req[NREQ-1:1];
        pick0   = req[0] && !(others && (consec == CON_W'(MAX_CONSEC)));
        rr_hit  = 1'b0;
        rr_win  = '0;
        cand    = 0;
        for (int off = 1; off < NREQ; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - (NREQ - 1);
            end
            if (!rr_hit && req[ID_W'(cand)]) begin
                rr_hit = 1'b1;
                rr_win = ID_W'(cand);
            end
        end
        win_id = pick0 ? '0 : rr_win;
    end

    // Select the winning requester's command fields from the flattened buses.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_rd   = 1'b0;
        win_wr   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_addr = req_addr[16*i +: 16];
                win_data = req_data[32*i +: 32];
                win_rd   = req_rd[i];
                win_wr   = req_wr[i];
            end
        end
    end

    // Transaction sequencer: grant in IDLE, hold the bus in DRIVE, pulse ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register, including the bus address/data, is reset
            // so an aborted transaction leaves nothing driven and no ack.
            state        <= S_IDLE;
            hold_cnt     <= '0;
            rr_ptr       <= ID_W'(NREQ - 1);
            consec       <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            ack          <= '0;
            ack_rdata    <= '0;
            cmd_bus_addr <= '0;
            cmd_bus_data <= '0;
            cmd_bus_en   <= 1'b0;
            cmd_bus_rd   <= 1'b0;
            cmd_bus_wr   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state        <= S_DRIVE;
                        hold_cnt     <= CNT_W'(HOLD_CYCLES - 1);
                        grant_id     <= win_id;
                        busy         <= 1'b1;
                        cmd_bus_addr <= win_addr;
                        cmd_bus_data <= win_data;
                        cmd_bus_en   <= 1'b1;
                        cmd_bus_wr   <= win_wr;
                        cmd_bus_rd   <= win_rd & ~win_wr;
                        if (pick0) begin
                            if (!others) begin
                                consec <= '0;
                            end else if (consec != CON_W'(MAX_CONSEC)) begin
                                consec <= consec + 1'b1;
                            end
                        end else begin
                            rr_ptr <= rr_win;
                            consec <= '0;
                        end
                    end
                end
                S_DRIVE: begin
                    if (hold_cnt == '0) begin
                        state      <= S_ACK;
                        cmd_bus_en <= 1'b0;
                        cmd_bus_rd <= 1'b0;
                        cmd_bus_wr <= 1'b0;
                        ack_rdata  <= cmd_bus_rdata;
                        ack        <= NREQ'(1) << grant_id;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    state        <= S_IDLE;
                    ack          <= '0;
                    busy         <= 1'b0;
                    cmd_bus_addr <= '0;
                    cmd_bus_data <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// tb_cmd_bus_arbiter
// Scoreboard bench: the stimulus process runs a transaction-level model of
// the arbitration rules and pushes each expected bus transaction; a separate
// monitor compares the bus, ack and read data as the DUT presents them.
module tb_cmd_bus_arbiter;

    localparam int NREQ = 3;
    localparam int HOLD = 2;
    localparam int MAXC = 4;
    localparam int IDW  = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ-1:0]      req_rd;
    logic [16*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic [31:0]          ack_rdata;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic [15:0]          cmd_bus_addr;
    logic [31:0]          cmd_bus_data;
    logic                 cmd_bus_en;
    logic                 cmd_bus_rd;
    logic                 cmd_bus_wr;
    logic [31:0]          cmd_bus_rdata;

    cmd_bus_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .MAX_CONSEC(MAXC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_rd(req_rd),
        .req_addr(req_addr), .req_data(req_data), .ack(ack), .ack_rdata(ack_rdata),
        .busy(busy), .grant_id(grant_id), .cmd_bus_addr(cmd_bus_addr),
        .cmd_bus_data(cmd_bus_data), .cmd_bus_en(cmd_bus_en), .cmd_bus_rd(cmd_bus_rd),
        .cmd_bus_wr(cmd_bus_wr), .cmd_bus_rdata(cmd_bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Requester-side state
    logic        pend[NREQ];
    logic [15:0] c_addr[NREQ];
    logic [31:0] c_data[NREQ];
    logic        c_rd[NREQ];
    logic        c_wr[NREQ];
    logic        auto_refill[NREQ];
    int          spont_pct   = 0;
    int          refill_pct  = 0;
    int          garble_mode = 0;
    logic        use_forced  = 1'b0;
    logic [31:0] forced_rdata = '0;

    // Arbitration model state
    int          m_rr;
    int          m_consec;
    int          wait_cnt;
    int          gid;
    logic        locked;
    logic [31:0] cur_rdata;

    int          grant_log[$];
    int          ack_cyc[$];
    int          mcyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = pend[i];
            req_wr[i]           = c_wr[i];
            req_rd[i]           = c_rd[i];
            req_addr[16*i +: 16] = c_addr[i];
            req_data[32*i +: 32] = c_data[i];
        end
    endtask

    task automatic set_cmd(input int i, input logic [15:0] a, input logic [31:0] d,
                           input logic rd, input logic wr);
        pend[i]   = 1'b1;
        c_addr[i] = a;
        c_data[i] = d;
        c_rd[i]   = rd;
        c_wr[i]   = wr;
    endtask

    task automatic new_cmd(input int i);
        logic [1:0] kind;
        kind = 2'($urandom_range(0, 3));
        set_cmd(i, 16'($urandom()), $urandom(), kind[0], kind[1]);
    endtask

    task automatic model_reset();
        sb.delete();
        wait_cnt = 0;
        locked   = 1'b0;
        gid      = 0;
        m_rr     = NREQ - 1;
        m_consec = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]        = 1'b0;
            auto_refill[i] = 1'b0;
            c_addr[i]      = '0;
            c_data[i]      = '0;
            c_rd[i]        = 1'b0;
            c_wr[i]        = 1'b0;
        end
        drive();
    endtask

    // Decide who the arbiter serves from the set of pending requesters.
    task automatic decide();
        logic others;
        int   w;
        txn_t t;
        others = 1'b0;
        for (int i = 1; i < NREQ; i++) if (pend[i]) others = 1'b1;
        w = -1;
        if (pend[0] && !(others && m_consec >= MAXC)) begin
            w = 0;
            m_consec = others ? ((m_consec < MAXC) ? m_consec + 1 : MAXC) : 0;
        end else begin
            for (int k = 1; k < NREQ; k++) begin
                int cand;
                cand = ((m_rr - 1 + k) % (NREQ - 1)) + 1;
                if (w < 0 && pend[cand]) w = cand;
            end
            m_rr     = w;
            m_consec = 0;
        end
        cur_rdata = use_forced ? forced_rdata : $urandom();
        t.id    = w;
        t.addr  = c_addr[w];
        t.data  = c_data[w];
        t.wr    = c_wr[w];
        t.rd    = c_rd[w] & ~c_wr[w];
        t.rdata = cur_rdata;
        sb.push_back(t);
        gid      = w;
        locked   = 1'b1;
        wait_cnt = HOLD + 1;
    endtask

    // One cycle of requester behaviour, applied at the falling edge.
    task automatic step();
        logic any;
        @(negedge clk);
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (garble_mode == 2 || (garble_mode == 1 && $urandom_range(0, 3) == 0)) begin
                pend[gid]   = (garble_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                c_addr[gid] = 16'($urandom());
                c_data[gid] = $urandom();
            end
            cmd_bus_rdata = (wait_cnt == 1) ? cur_rdata : $urandom();
            for (int i = 0; i < NREQ; i++)
                if (i != gid && !pend[i] && $urandom_range(0, 99) < spont_pct) new_cmd(i);
        end else begin
            cmd_bus_rdata = $urandom();
            if (locked) begin
                locked = 1'b0;
                if (auto_refill[gid] || $urandom_range(0, 99) < refill_pct) new_cmd(gid);
                else pend[gid] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 99) < spont_pct) new_cmd(i);
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (pend[i]) any = 1'b1;
            if (any) decide();
        end
        drive();
    endtask

    task automatic drain(input string name);
        logic any;
        for (int n = 0; n < 400; n++) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (pend[i]) any = 1'b1;
            if (sb.size() == 0 && wait_cnt == 0 && !locked && !any) break;
            step();
        end
        repeat (2) @(negedge clk);
        check({"drain_", name}, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_en_rd_wr"}, 64'({cmd_bus_en, cmd_bus_rd, cmd_bus_wr}), 64'd0);
        check({name, "_addr_data"}, 64'({cmd_bus_addr, cmd_bus_data}), 64'd0);
        check({name, "_ack_busy"}, 64'({ack, busy, grant_id}), 64'd0);
        check({name, "_ack_rdata"}, 64'(ack_rdata), 64'd0);
    endtask

    // Monitor: compares bus activity and acks against the scoreboard head.
    initial begin
        int   en_len;
        logic in_txn;
        logic post_ack;
        en_len   = 0;
        in_txn   = 1'b0;
        post_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (!rst) begin
                in_txn   = 1'b0;
                post_ack = 1'b0;
            end else if (cmd_bus_en) begin
                post_ack = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_en", 64'(cmd_bus_en), 64'd0);
                end else begin
                    if (!in_txn) begin
                        in_txn = 1'b1;
                        en_len = 0;
                        check("busy_in_drive", 64'(busy), 64'd1);
                        check("grant_id", 64'(grant_id), 64'(sb[0].id));
                    end
                    en_len++;
                    check("bus_addr", 64'(cmd_bus_addr), 64'(sb[0].addr));
                    check("bus_data", 64'(cmd_bus_data), 64'(sb[0].data));
                    check("bus_wr", 64'(cmd_bus_wr), 64'(sb[0].wr));
                    check("bus_rd", 64'(cmd_bus_rd), 64'(sb[0].rd));
                    check("ack_during_drive", 64'(ack), 64'd0);
                end
            end else if (in_txn) begin
                in_txn = 1'b0;
                check("hold_len", 64'(en_len), 64'(HOLD));
                check("ack_onehot", 64'(ack), 64'(NREQ'(1) << sb[0].id));
                if (sb[0].rd) check("ack_rdata", 64'(ack_rdata), 64'(sb[0].rdata));
                check("busy_in_ack", 64'(busy), 64'd1);
                check("strobes_in_ack", 64'({cmd_bus_rd, cmd_bus_wr}), 64'd0);
                grant_log.push_back(sb[0].id);
                ack_cyc.push_back(mcyc);
                void'(sb.pop_front());
                post_ack = 1'b1;
            end else begin
                check("spurious_ack", 64'(ack), 64'd0);
                if (post_ack) begin
                    check("busy_after_ack", 64'(busy), 64'd0);
                    post_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fair_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int rr_pat[6]    = '{1, 2, 1, 2, 1, 2};

        cmd_bus_rdata = '0;
        model_reset();
        rst = 1'b0;

        // Reset held with random requests: everything stays quiet.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            req      = NREQ'($urandom());
            req_wr   = NREQ'($urandom());
            req_rd   = NREQ'($urandom());
            req_addr = (16*NREQ)'({$urandom(), $urandom()});
            req_data = (32*NREQ)'({$urandom(), $urandom(), $urandom()});
            cmd_bus_rdata = $urandom();
            @(posedge clk);
            #2;
            check_quiet("rst_hold");
        end
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_quiet("after_reset");

        // Single write from requester 1.
        set_cmd(1, 16'h0012, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drain("write1");

        // Read from requester 2 with a known return word.
        use_forced   = 1'b1;
        forced_rdata = 32'hA5A5_0001;
        set_cmd(2, 16'h0345, 32'h0000_0000, 1'b1, 1'b0);
        drain("read2");
        use_forced = 1'b0;

        // rd and wr together behave as a write.
        set_cmd(2, 16'h0777, 32'h1234_5678, 1'b1, 1'b1);
        drain("rdwr");

        // Requester drops req and scrambles its address mid-transaction.
        garble_mode = 2;
        set_cmd(1, 16'h0ABC, 32'hCAFE_F00D, 1'b0, 1'b1);
        drain("drop");
        garble_mode = 0;

        // Reset in the middle of DRIVE: bus drops at once, no ack follows.
        set_cmd(1, 16'h0F0F, 32'h5555_AAAA, 1'b0, 1'b1);
        step();
        @(posedge clk);
        #2;
        check("en_before_abort", 64'(cmd_bus_en), 64'd1);
        rst = 1'b0;
        #1;
        check("en_async_abort", 64'(cmd_bus_en), 64'd0);
        check("busy_async_abort", 64'(busy), 64'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #2;
            check("ack_during_abort", 64'(ack), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        set_cmd(2, 16'h0101, 32'h0BAD_CAFE, 1'b0, 1'b1);
        drain("after_abort");

        // Priority with fairness: 0 and 1 requesting continuously.
        do_reset();
        grant_log.delete();
        ack_cyc.delete();
        auto_refill[0] = 1'b1;
        auto_refill[1] = 1'b1;
        new_cmd(0);
        new_cmd(1);
        for (int n = 0; n < 200 && grant_log.size() < 10; n++) step();
        auto_refill[0] = 1'b0;
        auto_refill[1] = 1'b0;
        drain("fair");
        if (grant_log.size() < 10) begin
            check("fair_count", 64'(grant_log.size()), 64'd10);
        end else begin
            for (int i = 0; i < 10; i++) check("fair_order", 64'(grant_log[i]), 64'(fair_pat[i]));
            for (int i = 0; i < 9; i++)
                check("fair_spacing", 64'(ack_cyc[i+1] - ack_cyc[i]), 64'(HOLD + 2));
        end

        // Round-robin between 1 and 2 straight after reset.
        do_reset();
        grant_log.delete();
        auto_refill[1] = 1'b1;
        auto_refill[2] = 1'b1;
        new_cmd(1);
        new_cmd(2);
        for (int n = 0; n < 200 && grant_log.size() < 6; n++) step();
        auto_refill[1] = 1'b0;
        auto_refill[2] = 1'b0;
        drain("rr");
        if (grant_log.size() < 6) begin
            check("rr_count", 64'(grant_log.size()), 64'd6);
        end else begin
            for (int i = 0; i < 6; i++) check("rr_order", 64'(grant_log[i]), 64'(rr_pat[i]));
        end

        // Randomized traffic against the model.
        do_reset();
        spont_pct   = 30;
        refill_pct  = 50;
        garble_mode = 1;
        repeat (600) step();
        spont_pct   = 0;
        refill_pct  = 0;
        garble_mode = 0;
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
